// File: rtl/adder_arb_pkg.sv
// Shared types and sizing for the adder arbiter.
// One-hot FSM encoding and watchdog counter width helper.
package adder_arb_pkg;

  localparam int WIDTH_DEF   = 513;
  localparam int TIMEOUT_DEF = 16;

  function automatic int to_w(input int t);
    return $clog2(t + 1);
  endfunction

  localparam int TO_W = to_w(TIMEOUT_DEF);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_START   = 5'b00010,
    S_WAIT    = 5'b00100,
    S_CAPTURE = 5'b01000,
    S_RESP    = 5'b10000
  } state_t;

endpackage

// File: rtl/adder_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; the last pointer lives in the parent.
// On a tie the requester that was not served last wins.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic en,
  output logic grant_valid,
  output logic gnt_id
);

  always_comb begin
    grant_valid = en & (req0 | req1);
    gnt_id      = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one multi-cycle adder between two requesters.
// Round-robin grant, start/done sequencing, result capture, watchdog.
import adder_arb_pkg::*;

module adder_arbiter #(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             sub0,
  input  logic             sub1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             err_timeout,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);

  localparam int CW = to_w(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_t state, state_n;

  logic             last;
  logic             gnt_id;
  logic             op_sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CW-1:0]    wd;

  logic grant_valid;
  logic win;
  logic wd_fire;

  rr_arbiter2 u_rr (
    .req0        (req0),
    .req1        (req1),
    .last        (last),
    .en          (state == S_IDLE),
    .grant_valid (grant_valid),
    .gnt_id      (win)
  );

  assign wd_fire = (state == S_WAIT) & ~add_done & (wd == WD_LAST);

  always_comb begin
    state_n   = state;
    add_start = 1'b0;
    busy      = 1'b1;
    done0     = 1'b0;
    done1     = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (grant_valid) state_n = S_START;
      end
      S_START: begin
        add_start = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (add_done)     state_n = S_CAPTURE;
        else if (wd_fire) state_n = S_IDLE;
      end
      S_CAPTURE: state_n = S_RESP;
      S_RESP: begin
        done0   = ~gnt_id;
        done1   = gnt_id;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      last        <= 1'b1;
      gnt_id      <= 1'b0;
      op_sub      <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      wd          <= '0;
      err_timeout <= 1'b0;
      result      <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && grant_valid) begin
        gnt_id <= win;
        last   <= win;
        op_sub <= win ? sub1 : sub0;
        op_a   <= win ? a1 : a0;
        op_b   <= win ? b1 : b0;
      end
      if (state == S_START)     wd <= '0;
      else if (state == S_WAIT) wd <= wd + CW'(1);
      if (wd_fire)              err_timeout <= 1'b1;
      if (state == S_CAPTURE)   result <= add_result;
    end
  end

  // Adder operands come straight from the op registers, never from req.
  assign add_subtract = op_sub;
  assign add_a        = op_a;
  assign add_b        = op_b;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural 5-cycle adder.
// Checks grant order, latency, results, watchdog and reset.
module tb_adder_arbiter;

  localparam int W = 513;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, sub0, sub1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         done0, done1, busy, err_timeout;
  logic [W:0]   result;
  logic         add_start, add_subtract, add_done;
  logic [W-1:0] add_a, add_b;
  logic [W:0]   add_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .sub0         (sub0),
    .sub1         (sub1),
    .a0           (a0),
    .b0           (b0),
    .a1           (a1),
    .b1           (b1),
    .done0        (done0),
    .done1        (done1),
    .result       (result),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .add_start    (add_start),
    .add_subtract (add_subtract),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_result   (add_result),
    .add_done     (add_done)
  );

  // Adder model: start seen at edge, done in the 5th cycle, result next.
  logic       resetn;
  logic       mdl_en;
  logic [2:0] acnt;
  assign resetn   = ~reset;
  assign add_done = (acnt == 3'd5);

  always @(posedge clk) begin
    if (!resetn) begin
      acnt       <= 3'd0;
      add_result <= '0;
    end else if (add_start && mdl_en) begin
      acnt <= 3'd1;
    end else if (acnt == 3'd5) begin
      acnt       <= 3'd0;
      add_result <= add_subtract ? ({1'b0, add_a} - {1'b0, add_b})
                                 : ({1'b0, add_a} + {1'b0, add_b});
    end else if (acnt != 3'd0) begin
      acnt <= acnt + 3'd1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W:0] obs,
                     input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [W:0] minus2;

  initial begin
    minus2 = ~({(W+1){1'b0}} | 1);
    reset = 1'b1;
    mdl_en = 1'b1;
    req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_done0", done0, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_start", add_start, 0);
    reset = 1'b0;
    tick(1);

    // single add, operands altered after grant
    req0 = 1; a0 = 5; b0 = 7; sub0 = 0;
    tick(1);
    chk("add_start_c1", add_start, 1);
    chk("add_a_c1", add_a, 5);
    chk("busy_c1", busy, 1);
    tick(1);
    chk("add_start_c2", add_start, 0);
    a0 = 1000; b0 = 2000;
    tick(5);
    chk("done0_c7", done0, 0);
    tick(1);
    chk("done0_c8", done0, 1);
    chk("done1_c8", done1, 0);
    chk("result_add", result, 12);
    req0 = 0;
    tick(1);
    chk("done0_c9", done0, 0);
    chk("busy_c9", busy, 0);
    chk("result_hold", result, 12);

    // subtraction wrapping negative
    req1 = 1; a1 = 3; b1 = 5; sub1 = 1;
    tick(1);
    chk("sub_flag", add_subtract, 1);
    tick(7);
    chk("done1_sub", done1, 1);
    chk("done0_sub", done0, 0);
    chk("result_sub", result, minus2);
    req1 = 0;
    tick(1);

    // tie, twice: req0 first both times
    for (int r = 0; r < 2; r++) begin
      req0 = 1; a0 = 10; b0 = 1; sub0 = 0;
      req1 = 1; a1 = 20; b1 = 4; sub1 = 1;
      tick(8);
      chk("tie_done0", done0, 1);
      chk("tie_done1_early", done1, 0);
      chk("tie_res0", result, 11);
      req0 = 0;
      tick(8);
      chk("tie_done1_c16", done1, 0);
      tick(1);
      chk("tie_done1", done1, 1);
      chk("tie_done0_late", done0, 0);
      chk("tie_res1", result, 16);
      req1 = 0;
      tick(1);
    end

    // watchdog
    mdl_en = 1'b0;
    req0 = 1; a0 = 1; b0 = 1; sub0 = 0;
    tick(8);
    chk("wd_nodone_c8", done0, 0);
    chk("wd_busy_c8", busy, 1);
    tick(9);
    chk("wd_err_c17", err_timeout, 0);
    tick(1);
    chk("wd_err_c18", err_timeout, 1);
    chk("wd_busy_c18", busy, 0);
    chk("wd_done_c18", done0, 0);
    req0 = 0;
    mdl_en = 1'b1;
    tick(1);

    // service continues after timeout
    req1 = 1; a1 = 40; b1 = 2; sub1 = 0;
    tick(8);
    chk("post_wd_done1", done1, 1);
    chk("post_wd_res", result, 42);
    chk("err_sticky", err_timeout, 1);
    req1 = 0;
    tick(1);

    // reset mid-operation
    req0 = 1; a0 = 9; b0 = 9; sub0 = 0;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("mr_busy", busy, 0);
    chk("mr_start", add_start, 0);
    chk("mr_a", add_a, 0);
    chk("mr_result", result, 0);
    chk("mr_err", err_timeout, 0);
    chk("mr_done0", done0, 0);
    reset = 1'b0;
    req0 = 0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      chk("mr_no_done0", done0, 0);
    end
    chk("mr_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
